// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl
//   Sequencer that time-shares an external 1-bit ALU slice to perform
//   WIDTH-bit operations bit-serially, LSB first. It holds the operand
//   shift registers, the carry/borrow register between bit-steps,
//   result assembly, SLT resolution and the status flags.
//
//   Optional feature: define BSALU_ABORT_EN to add the abort input, which
//   cancels a running operation without a done pulse or result update.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   start, op, a_in, b_in   issue request, sampled only in IDLE
//   abort                   (BSALU_ABORT_EN only) cancel a running op
//   busy, done              busy while not IDLE; done is a 1-cycle pulse
//   result, carry,
//   overflow, zero          result and flags, held until the next completion
//   alu_a, alu_b, alu_cin,
//   alu_op                  drive to the 1-bit slice (0 outside RUN)
//   alu_out, alu_cout       slice result bit and carry/borrow out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; slice outputs held at 0
// RUN   | one bit-step per clock, WIDTH steps, LSB first
// DONE  | result/flags just updated, done pulses for this one cycle

module bit_serial_alu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
`ifdef BSALU_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic [2:0]       alu_op,
   input  logic             alu_out,
   input  logic             alu_cout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_SLT  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   // Only WIDTH-1 bits are stored: on the last step the slice output
   // itself supplies the MSB of the final result.
   logic [WIDTH-2:0] res_sh_q, res_sh_d;
   logic             cy_q, cy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] res_cat;
   logic [WIDTH-1:0] fin_res;
   logic             fin_carry;
   logic             fin_ovf;
   logic             add_ovf;
   logic             sub_ovf;

   // Final-step resolution. On the last RUN cycle a_sh_q[0]/b_sh_q[0] are
   // the operand MSBs and alu_out is the result MSB.
   always_comb begin
      res_cat   = {alu_out, res_sh_q};
      add_ovf   = (a_sh_q[0] == b_sh_q[0]) && (alu_out != a_sh_q[0]);
      sub_ovf   = (a_sh_q[0] != b_sh_q[0]) && (alu_out != a_sh_q[0]);
      fin_res   = res_cat;
      fin_carry = 1'b0;
      fin_ovf   = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            fin_carry = alu_cout;
            fin_ovf   = add_ovf;
         end
         OP_SUB: begin
            fin_carry = alu_cout;
            fin_ovf   = sub_ovf;
         end
         OP_SLT: begin
            // Signed less-than: sign of the difference, corrected when the
            // subtraction overflowed.
            fin_res    = '0;
            fin_res[0] = alu_out ^ sub_ovf;
            fin_carry  = alu_cout;
         end
         OP_XOR, OP_AND, OP_NAND, OP_NOR, OP_OR: begin
            fin_carry = 1'b0;
            fin_ovf   = 1'b0;
         end
         default: begin
            fin_carry = 1'b0;
            fin_ovf   = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      cy_d     = cy_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      alu_a    = 1'b0;
      alu_b    = 1'b0;
      alu_cin  = 1'b0;
      alu_op   = 3'b000;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               op_d     = op;
               a_sh_d   = a_in;
               b_sh_d   = b_in;
               res_sh_d = '0;
               cy_d     = 1'b0;
               cnt_d    = CW'(WIDTH - 1);
            end
         end
         ST_RUN: begin
            alu_a   = a_sh_q[0];
            alu_b   = b_sh_q[0];
            alu_cin = cy_q;
            alu_op  = (op_q == OP_SLT) ? OP_SUB : op_q;
`ifdef BSALU_ABORT_EN
            if (abort) begin
               state_d = ST_IDLE;
            end else
`endif
            begin
               res_sh_d = res_cat[WIDTH-1:1];
               cy_d     = alu_cout;
               a_sh_d   = a_sh_q >> 1;
               b_sh_d   = b_sh_q >> 1;
               if (cnt_q == '0) begin
                  state_d  = ST_DONE;
                  result_d = fin_res;
                  carry_d  = fin_carry;
                  ovf_d    = fin_ovf;
                  zero_d   = (fin_res == '0);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         op_q     <= 3'b000;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         cy_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         cy_q     <= cy_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Testbench for bit_serial_alu_ctrl at WIDTH=8. Contains a behavioural
// 1-bit slice and an arithmetic reference model for whole-word results.

module tb_bit_serial_alu_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
`ifdef BSALU_ABORT_EN
   logic         abort;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry;
   logic         overflow;
   logic         zero;
   logic         alu_a;
   logic         alu_b;
   logic         alu_cin;
   logic [2:0]   alu_op;
   logic         alu_out;
   logic         alu_cout;

   int checks = 0;
   int errors = 0;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
`ifdef BSALU_ABORT_EN
      .abort    (abort),
`endif
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carry    (carry),
      .overflow (overflow),
      .zero     (zero),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_cin  (alu_cin),
      .alu_op   (alu_op),
      .alu_out  (alu_out),
      .alu_cout (alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-bit slice
   always_comb begin
      alu_out  = 1'b0;
      alu_cout = 1'b0;
      case (alu_op)
         3'b000: begin
            alu_out  = alu_a ^ alu_b ^ alu_cin;
            alu_cout = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
         end
         3'b001: begin
            alu_out  = alu_a ^ alu_b ^ alu_cin;
            alu_cout = (~alu_a & alu_b) | (~alu_a & alu_cin) | (alu_b & alu_cin);
         end
         3'b010: alu_out = alu_a ^ alu_b;
         3'b100: alu_out = alu_a & alu_b;
         3'b101: alu_out = ~(alu_a & alu_b);
         3'b110: alu_out = ~(alu_a | alu_b);
         3'b111: alu_out = alu_a | alu_b;
         default: alu_out = 1'b0;
      endcase
   end

   // Whole-word reference from plain arithmetic
   function automatic void model(input logic [2:0] m_op, input logic [W-1:0] a, b,
                                 output logic [W-1:0] r, output logic c, v, z);
      int sa, sb, sr;
      logic [W:0] s;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r = '0; c = 1'b0; v = 1'b0;
      case (m_op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; c = s[W];
            sr = sa + sb; v = (sr > 127) || (sr < -128);
         end
         3'd1: begin
            r = a - b; c = (a < b);
            sr = sa - sb; v = (sr > 127) || (sr < -128);
         end
         3'd3: begin
            r = (sa < sb) ? 8'd1 : 8'd0; c = (a < b);
         end
         3'd2: r = a ^ b;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      z = (r == '0);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issues one op; lat counts edges from the accepting edge (inclusive)
   // to the edge after which done is seen. poke_k >= 0 pulses a conflicting
   // start during RUN bit poke_k.
   task automatic run_op(input logic [2:0] op_v, input logic [W-1:0] a_v, b_v,
                         input int poke_k, output int lat,
                         output logic one_cycle, output logic op_ok);
      logic [2:0] exp_sop;
      exp_sop = (op_v == 3'b011) ? 3'b001 : op_v;
      @(negedge clk);
      start = 1'b1; op = op_v; a_in = a_v; b_in = b_v;
      lat = 0; op_ok = 1'b1; one_cycle = 1'b0;
      while (1) begin
         @(posedge clk); #1;
         lat++;
         start = 1'b0;
         if (done) break;
         if (lat > 40) break;
         if (alu_op !== exp_sop) op_ok = 1'b0;
         if (lat - 1 == poke_k) begin
            start = 1'b1; op = ~op_v; a_in = ~a_v; b_in = a_v ^ 8'h5A;
         end
      end
      @(posedge clk); #1;
      one_cycle = !done && !busy;
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int lat;
      logic one, opok, seen;
      logic [W-1:0] er, ra, rb;
      logic ec, ev, ez;
      logic [2:0] rop;

      vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{3'd1, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{3'd3, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{3'd3, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{3'd3, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{3'd2, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'd4, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{3'd5, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{3'd6, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{3'd7, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};

      reset_n = 1'b0; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
`ifdef BSALU_ABORT_EN
      abort = 1'b0;
`endif
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {carry, overflow, zero}, 0);
      chk("rst_slice", {alu_a, alu_b, alu_cin, alu_op}, 0);
      @(negedge clk); reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, one, opok);
         chk($sformatf("vec%0d_result", i), result, vecs[i].res);
         chk($sformatf("vec%0d_carry", i), carry, vecs[i].c);
         chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].v);
         chk($sformatf("vec%0d_zero", i), zero, vecs[i].z);
         chk($sformatf("vec%0d_latency", i), lat, W + 1);
         chk($sformatf("vec%0d_done_width", i), one, 1);
         chk($sformatf("vec%0d_alu_op", i), opok, 1);
      end

      // Start during RUN must be ignored
      run_op(3'd0, 8'h10, 8'h20, 4, lat, one, opok);
      chk("ignore_start_result", result, 8'h30);
      chk("ignore_start_latency", lat, W + 1);
      chk("ignore_start_idle_after", one, 1);

      // Reset in the middle of RUN
      @(negedge clk); start = 1'b1; op = 3'd0; a_in = 8'h10; b_in = 8'h22;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2; reset_n = 1'b0; #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_slice", {alu_a, alu_b, alu_cin, alu_op}, 0);
      @(negedge clk); reset_n = 1'b1;
      run_op(3'd0, 8'h10, 8'h22, -1, lat, one, opok);
      chk("postrst_result", result, 8'h32);
      chk("postrst_latency", lat, W + 1);

`ifdef BSALU_ABORT_EN
      run_op(3'd7, 8'hF0, 8'hCC, -1, lat, one, opok);
      chk("pre_abort_result", result, 8'hFC);
      @(negedge clk); start = 1'b1; op = 3'd0; a_in = 8'h01; b_in = 8'h01;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk);
      #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 8'hFC);
      chk("abort_slice", {alu_a, alu_b, alu_cin, alu_op}, 0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", seen, 0);
      run_op(3'd0, 8'h01, 8'h01, -1, lat, one, opok);
      chk("post_abort_result", result, 8'h02);
`endif

      // Randomized against the arithmetic model
      for (int i = 0; i < 150; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         if (i % 10 == 0) rb = ra;
         model(rop, ra, rb, er, ec, ev, ez);
         run_op(rop, ra, rb, -1, lat, one, opok);
         chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, rop, ra, rb), result, er);
         chk($sformatf("rnd%0d_carry", i), carry, ec);
         chk($sformatf("rnd%0d_overflow", i), overflow, ev);
         chk($sformatf("rnd%0d_zero", i), zero, ez);
         chk($sformatf("rnd%0d_latency", i), lat, W + 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
